// File: rtl/l1_line_fill_unit_if.sv
// Handshake and bus bundle for the L1 line fill unit.
// The master modport is the fill unit's view. The slave modport is the view of the lookup, memory and core side.
interface l1_line_fill_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 256
);
    localparam int LINE_W   = LINE_SIZE * 8;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int OFFSET_W = $clog2(LINE_SIZE);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;

    logic                  miss_valid;
    logic                  miss_ready;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [WAY_W-1:0]      miss_way;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;

    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  mem_rsp_err;

    logic                  fill_valid;
    logic [TAG_W-1:0]      fill_tag;
    logic [INDEX_W-1:0]    fill_index;
    logic [WAY_W-1:0]      fill_way;
    logic [LINE_W-1:0]     fill_data;
    logic                  fill_err;

    logic                  cpu_valid;
    logic [DATA_WIDTH-1:0] cpu_data;
    logic                  busy;

    modport master (
        input  miss_valid, miss_addr, miss_way, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output miss_ready, mem_req_valid, mem_req_addr,
               fill_valid, fill_tag, fill_index, fill_way, fill_data, fill_err,
               cpu_valid, cpu_data, busy
    );

    modport slave (
        output miss_valid, miss_addr, miss_way, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  miss_ready, mem_req_valid, mem_req_addr,
               fill_valid, fill_tag, fill_index, fill_way, fill_data, fill_err,
               cpu_valid, cpu_data, busy
    );
endinterface

// File: rtl/l1_line_fill_unit.sv
// L1 miss handler: requests a line, gathers its beats, writes the whole line in one cycle and returns the missed word.
// Optional macro L1_FILL_CWF_EN: critical-word-first wrapping burst, with an early return of the requested word.
module l1_line_fill_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 256
) (
    input  logic                clk,
    input  logic                rst,
    l1_line_fill_unit_if.master bus
);
    localparam int BEATS    = LINE_SIZE * 8 / DATA_WIDTH;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int BYTE_W   = $clog2(DATA_WIDTH / 8);
    localparam int WAY_W    = $clog2(WAYS);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int OFFSET_W = $clog2(LINE_SIZE);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, REQ, COLLECT, FILL} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic [ADDR_WIDTH-1:BYTE_W]    addr_q;
    logic [WAY_W-1:0]              way_q;
    logic [BEATS-1:0][DATA_WIDTH-1:0] line_q;

    logic                          capture;
    logic                          beat_we;
    logic [CNT_W-1:0]              word_off;
    logic [CNT_W-1:0]              start;
    logic [CNT_W-1:0]              slot;
    logic                          req_active;
    logic                          fill_active;
    logic                          cpu_valid_w;

    assign word_off    = addr_q[OFFSET_W-1:BYTE_W];
    assign slot        = start + cnt_q;
    assign req_active  = (state_q == REQ);
    assign fill_active = (state_q == FILL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        capture = 1'b0;
        beat_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.miss_valid) begin
                    capture = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.mem_rsp_valid) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    err_d   = err_q | bus.mem_rsp_err;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Captured miss and line buffer are pure data and are never reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= bus.miss_addr[ADDR_WIDTH-1:BYTE_W];
            way_q  <= bus.miss_way;
        end
        if (beat_we) begin
            line_q[slot] <= bus.mem_rsp_data;
        end
    end

`ifdef L1_FILL_CWF_EN
    logic cwf_q, cwf_d;

    // The first beat of a wrapping burst is the requested word, so it is returned as soon as it lands.
    assign cwf_d       = beat_we && (cnt_q == '0);
    assign start       = word_off;
    assign cpu_valid_w = cwf_q;
    assign bus.mem_req_addr = req_active ? {addr_q, BYTE_W'(0)} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cwf_q <= 1'b0;
        end else begin
            cwf_q <= cwf_d;
        end
    end
`else
    assign start       = '0;
    assign cpu_valid_w = fill_active;
    assign bus.mem_req_addr = req_active ? {addr_q[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)} : '0;
`endif

    assign bus.miss_ready    = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.mem_req_valid = req_active;

    // Data outputs are gated so that nothing from the unreset buffer is visible outside a strobe.
    assign bus.fill_valid = fill_active;
    assign bus.fill_tag   = fill_active ? addr_q[ADDR_WIDTH-1 -: TAG_W] : '0;
    assign bus.fill_index = fill_active ? addr_q[OFFSET_W +: INDEX_W] : '0;
    assign bus.fill_way   = fill_active ? way_q : '0;
    assign bus.fill_data  = fill_active ? line_q : '0;
    assign bus.fill_err   = fill_active & err_q;
    assign bus.cpu_valid  = cpu_valid_w;
    assign bus.cpu_data   = cpu_valid_w ? line_q[word_off] : '0;
endmodule

// File: tb/tb_l1_line_fill_unit.sv
// Self-checking bench for l1_line_fill_unit: a table of directed misses, hand-written reset sequences, and random misses checked against a line model.
module tb_l1_line_fill_unit;
`ifdef L1_FILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_line_fill_unit_if bus ();
    l1_line_fill_unit dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  way;
        int          req_wait;
        int          gap;
        logic [7:0]  err;
        logic [31:0] base;
        logic [18:0] e_tag;
        logic [7:0]  e_idx;
        logic        e_err;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] beat_d [8];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input bit e_req, input bit e_fill, input bit e_cpu, input bit e_idle);
        tick();
        chk("mem_req_valid", bus.mem_req_valid, e_req);
        chk("fill_valid", bus.fill_valid, e_fill);
        chk("cpu_valid", bus.cpu_valid, e_cpu);
        chk("miss_ready", bus.miss_ready, e_idle);
        chk("busy", bus.busy, !e_idle);
    endtask

    task automatic clear_inputs();
        bus.miss_valid    = 1'b0;
        bus.miss_addr     = '0;
        bus.miss_way      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_err   = 1'b0;
    endtask

    // The line model places beat i at word (start + i) mod 8. The requested word is word addr[4:2].
    task automatic run_miss(input logic [31:0] addr, input logic [1:0] way, input int req_wait,
                            input int gap, input logic [7:0] err_mask,
                            output logic [18:0] got_tag, output logic [7:0] got_idx, output logic got_err);
        logic [255:0] exp_line;
        logic [31:0]  exp_req;
        int off, start, g;
        off   = int'(addr[4:2]);
        start = CWF ? off : 0;
        exp_line = '0;
        for (int i = 0; i < 8; i++) exp_line[32*((start + i) % 8) +: 32] = beat_d[i];
        exp_req = CWF ? {addr[31:2], 2'b00} : {addr[31:5], 5'b00000};

        bus.miss_valid = 1'b1;
        bus.miss_addr  = addr;
        bus.miss_way   = way;
        chk("miss_ready_before", bus.miss_ready, 1'b1);
        step_chk(1'b1, 1'b0, 1'b0, 1'b0);
        bus.miss_valid = 1'b0;
        bus.miss_addr  = $urandom;
        bus.miss_way   = 2'($urandom);
        chk("mem_req_addr", bus.mem_req_addr, exp_req);
        for (int w = 0; w < req_wait; w++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = $urandom;
            bus.mem_rsp_err   = 1'b1;
            step_chk(1'b1, 1'b0, 1'b0, 1'b0);
            chk("mem_req_addr_hold", bus.mem_req_addr, exp_req);
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_err   = 1'b0;
        bus.mem_req_ready = 1'b1;
        step_chk(1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                bus.mem_rsp_data = $urandom;
                step_chk(1'b0, 1'b0, 1'b0, 1'b0);
            end
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beat_d[i];
            bus.mem_rsp_err   = err_mask[i];
            step_chk(1'b0, i == 7, CWF ? (i == 0) : (i == 7), 1'b0);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_err   = 1'b0;
            if (CWF && i == 0) chk("cpu_data_early", bus.cpu_data, exp_line[32*off +: 32]);
        end
        chk("fill_data", bus.fill_data, exp_line);
        chk("fill_tag", bus.fill_tag, addr[31:13]);
        chk("fill_index", bus.fill_index, addr[12:5]);
        chk("fill_way", bus.fill_way, way);
        chk("fill_err", bus.fill_err, |err_mask);
        if (!CWF) chk("cpu_data_fill", bus.cpu_data, exp_line[32*off +: 32]);
        got_tag = bus.fill_tag;
        got_idx = bus.fill_index;
        got_err = bus.fill_err;
        // Beats arriving in FILL and in IDLE must be ignored.
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = $urandom;
        step_chk(1'b0, 1'b0, 1'b0, 1'b1);
        step_chk(1'b0, 1'b0, 1'b0, 1'b1);
        bus.mem_rsp_valid = 1'b0;
    endtask

    initial begin
        logic [18:0] t;
        logic [7:0]  x;
        logic        e;

        vecs[0] = '{32'h1234_5678, 2'd2, 0, 0, 8'h00, 32'hA0,  19'h091A2, 8'hB3, 1'b0};
        vecs[1] = '{32'h0000_001C, 2'd1, 3, 1, 8'h00, 32'h100, 19'h00000, 8'h00, 1'b0};
        vecs[2] = '{32'hFFFF_FFE0, 2'd3, 1, 0, 8'h08, 32'hC0,  19'h7FFFF, 8'hFF, 1'b1};
        vecs[3] = '{32'h8000_2004, 2'd0, 0, 0, 8'h00, 32'hD0,  19'h40001, 8'h00, 1'b0};
        vecs[4] = '{32'h0000_1FE8, 2'd1, 2, 2, 8'hFF, 32'hE0,  19'h00000, 8'hFF, 1'b1};

        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_miss_ready", bus.miss_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_fill_valid", bus.fill_valid, 1'b0);
        chk("rst_cpu_valid", bus.cpu_valid, 1'b0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        rst = 1'b0;
        step_chk(1'b0, 1'b0, 1'b0, 1'b1);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) beat_d[i] = vecs[v].base + 32'(i);
            run_miss(vecs[v].addr, vecs[v].way, vecs[v].req_wait, vecs[v].gap, vecs[v].err, t, x, e);
            chk("vec_tag", t, vecs[v].e_tag);
            chk("vec_index", x, vecs[v].e_idx);
            chk("vec_err", e, vecs[v].e_err);
        end

        // Reset after four beats: nothing may be emitted, and stray beats afterwards are ignored.
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0BAD_F00C;
        bus.miss_way   = 2'd1;
        step_chk(1'b1, 1'b0, 1'b0, 1'b0);
        bus.miss_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        step_chk(1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'h5000 + 32'(i);
            step_chk(1'b0, 1'b0, CWF && (i == 0), 1'b0);
        end
        rst = 1'b1;
        step_chk(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step_chk(1'b0, 1'b0, 1'b0, 1'b1);
        bus.mem_rsp_valid = 1'b0;

        // Reset in REQ, then miss_valid together with reset while idle.
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h2222_0040;
        step_chk(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step_chk(1'b0, 1'b0, 1'b0, 1'b1);
        step_chk(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        bus.miss_valid = 1'b0;
        step_chk(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) beat_d[i] = 32'hF0 + 32'(i);
        run_miss(32'h1234_5678, 2'd3, 0, 0, 8'h00, t, x, e);

        for (int n = 0; n < 25; n++) begin
            logic [31:0] a;
            logic [7:0]  em;
            a  = $urandom;
            em = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            for (int i = 0; i < 8; i++) beat_d[i] = $urandom;
            run_miss(a, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, em, t, x, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
